mwfifo_ctrl: RTL and testbench

- Single-clock FIFO controller that drives an external dpmram as a wide-in / narrow-out buffer.
- A wide stream is written on dpmram port A; narrow words are read back through dpmram port B, which is read-only in this use.
- The block owns the pointers, occupancy accounting, read-latency tracking, and a small output skid FIFO, and presents valid/ready streams on both sides.
- It sits between a wide producer (e.g. a bus-width packer) and a narrow consumer.

---
 rtl/mwfifo_pkg.sv | 31 +++
 rtl/mwfifo_obuf.sv | 60 ++++++
 rtl/mwfifo_ctrl.sv | 116 +++++++++++
 tb/tb_mwfifo_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mwfifo_pkg.sv
`default_nettype none
// mwfifo_pkg: shared helpers for the wide-in / narrow-out FIFO controller.
package mwfifo_pkg;

  // Output-buffer entries beyond the RAM read latency; this slack lets a read
  // issue every cycle while the consumer keeps m_ready high.
  localparam int OB_SLACK = 2;

  function automatic int rd_latency(input logic [7:0] regout);
    return (regout == "Y") ? 2 : 1;
  endfunction

  function automatic int ob_depth(input logic [7:0] regout);
    return rd_latency(regout) + OB_SLACK;
  endfunction

  function automatic int log2_ratio(input int ratio);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < ratio) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mwfifo_obuf.sv
`default_nettype none
// mwfifo_obuf: small register FIFO with push/pop/count; head word comes straight from a register.
module mwfifo_obuf #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [DWIDTH-1:0]            data_i,
  input  logic                         pop_i,
  output logic [DWIDTH-1:0]            data_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A push into a full buffer is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    wr_idx_d = do_push ? next_idx(wr_idx_q) : wr_idx_q;
    rd_idx_d = do_pop ? next_idx(rd_idx_q) : rd_idx_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx_q] <= data_i;
  end

  assign data_o  = mem_q[rd_idx_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mwfifo_ctrl.sv
`default_nettype none
// mwfifo_ctrl: wide-in / narrow-out FIFO controller driving an external dpmram
// (port A writes wide words, port B reads narrow words, lowest lane first).
module mwfifo_ctrl
  import mwfifo_pkg::*;
#(
  parameter int         FDWIDTH = 32,
  parameter int         FAWIDTH = 8,
  parameter int         SDWIDTH = 16,
  parameter logic [7:0] REGOUT  = "Y",
  parameter int         RATIO   = FDWIDTH / SDWIDTH,
  parameter int         SAWIDTH = FAWIDTH + $clog2(RATIO)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FDWIDTH-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [SDWIDTH-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [SAWIDTH:0]   level,
  output logic               ram_wea,
  output logic [FAWIDTH-1:0] ram_addra,
  output logic [FDWIDTH-1:0] ram_dataa,
  output logic [SAWIDTH-1:0] ram_addrb,
  input  logic [SDWIDTH-1:0] ram_qb
);

  localparam int L       = rd_latency(REGOUT);
  localparam int OBDEPTH = ob_depth(REGOUT);
  localparam int LOGR    = log2_ratio(RATIO);
  localparam int CW      = $clog2(OBDEPTH + 1);
  localparam int LW      = SAWIDTH + 1;
  localparam logic [LW-1:0] THRESH = LW'((1 << SAWIDTH) - RATIO);

  if (FDWIDTH < SDWIDTH) begin : g_chk_width
    $error("mwfifo_ctrl: FDWIDTH must be >= SDWIDTH");
  end
  if (!is_pow2(RATIO)) begin : g_chk_ratio
    $error("mwfifo_ctrl: FDWIDTH/SDWIDTH must be a power of 2");
  end
  if ((REGOUT != "Y") && (REGOUT != "N")) begin : g_chk_regout
    $error("mwfifo_ctrl: REGOUT must be \"Y\" or \"N\"");
  end

  logic [FAWIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [SAWIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [L-1:0]     pipe_q, pipe_d;
  logic [SAWIDTH:0] level_q, level_d;
  logic [SAWIDTH:0] wr_narrow, stored;
  logic [CW-1:0]    ob_cnt, inflight;
  logic             wr_fire, issue, ob_push, ob_pop, ob_empty;

  assign wr_narrow = LW'(wr_ptr_q) << LOGR;
  assign stored    = wr_narrow - rd_ptr_q;

  // Ready depends only on registered state, so a producer may wait on it.
  assign s_ready   = rst_n && (stored <= THRESH);
  assign wr_fire   = s_valid && s_ready;
  assign ram_wea   = wr_fire;
  assign ram_addra = wr_ptr_q[FAWIDTH-1:0];
  assign ram_dataa = s_data;
  assign ram_addrb = rd_ptr_q[SAWIDTH-1:0];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < L; i++) inflight = inflight + CW'(pipe_q[i]);
  end

  // Credit: a read issues only if its word is guaranteed a buffer slot on arrival.
  assign issue   = (stored != '0) && ((ob_cnt + inflight) < CW'(OBDEPTH));
  assign ob_push = pipe_q[L-1];
  assign ob_pop  = m_valid && m_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (FAWIDTH + 1)'(wr_fire);
    rd_ptr_d = rd_ptr_q + LW'(issue);
    pipe_d   = L'({pipe_q, issue});
    // Issue and arrival move words internally; only handshakes change the total.
    level_d  = level_q + (wr_fire ? LW'(RATIO) : '0) - LW'(ob_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pipe_q   <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pipe_q   <= pipe_d;
      level_q  <= level_d;
    end
  end

  mwfifo_obuf #(
    .DWIDTH (SDWIDTH),
    .DEPTH  (OBDEPTH)
  ) u_obuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ob_push),
    .data_i  (ram_qb),
    .pop_i   (ob_pop),
    .data_o  (m_data),
    .empty_o (ob_empty),
    .count_o (ob_cnt)
  );

  assign m_valid = !ob_empty;
  assign level   = level_q;

endmodule
`default_nettype wire

// File: tb/tb_mwfifo_ctrl.sv
`default_nettype none
// tb_mwfifo_ctrl: directed bench with a 32->16 "Y" instance (a) and a 16->16 "N" instance (b).
module tb_mwfifo_ctrl;

  logic clk;
  logic rst_n;

  logic [31:0] a_s_data;
  logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_wea;
  logic [15:0] a_m_data, a_qb;
  logic [3:0]  a_level;
  logic [1:0]  a_addra;
  logic [31:0] a_dataa;
  logic [2:0]  a_addrb;

  logic [15:0] b_s_data;
  logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_wea;
  logic [15:0] b_m_data, b_qb;
  logic [2:0]  b_level;
  logic [1:0]  b_addra;
  logic [15:0] b_dataa;
  logic [1:0]  b_addrb;

  int checks = 0;
  int errors = 0;

  mwfifo_ctrl #(.FDWIDTH(32), .FAWIDTH(2), .SDWIDTH(16), .REGOUT("Y")) u_a (
    .clk(clk), .rst_n(rst_n), .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready), .level(a_level),
    .ram_wea(a_wea), .ram_addra(a_addra), .ram_dataa(a_dataa), .ram_addrb(a_addrb), .ram_qb(a_qb)
  );

  mwfifo_ctrl #(.FDWIDTH(16), .FAWIDTH(2), .SDWIDTH(16), .REGOUT("N")) u_b (
    .clk(clk), .rst_n(rst_n), .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .level(b_level),
    .ram_wea(b_wea), .ram_addra(b_addra), .ram_dataa(b_dataa), .ram_addrb(b_addrb), .ram_qb(b_qb)
  );

  // dpmram models: "Y" has address + output registers, "N" only the address register.
  logic [31:0] mem_a [4];
  logic [15:0] a_r1, a_r2;
  always @(posedge clk) begin
    if (a_wea) mem_a[a_addra] <= a_dataa;
    a_r1 <= a_addrb[0] ? mem_a[a_addrb[2:1]][31:16] : mem_a[a_addrb[2:1]][15:0];
    a_r2 <= a_r1;
  end
  assign a_qb = a_r2;

  logic [15:0] mem_b [4];
  logic [15:0] b_r1;
  always @(posedge clk) begin
    if (b_wea) mem_b[b_addra] <= b_dataa;
    b_r1 <= mem_b[b_addrb];
  end
  assign b_qb = b_r1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] wa(input int base, input int n);
    return {16'(base + 2 * n + 1), 16'(base + 2 * n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_s_valid = 0; a_s_data = '0; a_m_ready = 0;
    b_s_valid = 0; b_s_data = '0; b_m_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    a_s_valid = 1;
    a_s_data  = 32'h11112222;
    @(posedge clk);
    #1;
    checks++; if (a_s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %0b exp 0", a_s_ready); end
    checks++; if (a_wea !== 1'b0) begin errors++; $display("FAIL reset_wea got %0b exp 0", a_wea); end
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b exp 0", a_m_valid); end
    checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", a_level); end
    checks++; if (b_s_ready !== 1'b0) begin errors++; $display("FAIL reset_b_s_ready got %0b exp 0", b_s_ready); end
    a_s_valid = 0;
    @(posedge clk);
    #1 rst_n = 1;
    smp();
    checks++; if (a_s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %0b exp 1", a_s_ready); end
    checks++; if (b_s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_b_s_ready got %0b exp 1", b_s_ready); end
  endtask

  task automatic test_latency();
    logic        ev [7];
    logic [15:0] ed [7];
    ev = '{0, 0, 0, 0, 1, 1, 0};
    ed = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hCCDD, 16'hAABB, 16'h0};
    do_reset();
    tick();
    a_m_ready = 1; a_s_valid = 1; a_s_data = 32'hAABBCCDD;
    smp();
    checks++; if (a_wea !== 1'b1) begin errors++; $display("FAIL lat_wea got %0b exp 1", a_wea); end
    checks++; if (a_addra !== 2'd0) begin errors++; $display("FAIL lat_addra got %0d exp 0", a_addra); end
    checks++; if (a_dataa !== 32'hAABBCCDD) begin errors++; $display("FAIL lat_dataa got %h exp aabbccdd", a_dataa); end
    for (int c = 1; c <= 6; c++) begin
      tick();
      a_s_valid = 0;
      smp();
      if (c == 1) begin
        checks++; if (a_level !== 4'd2) begin errors++; $display("FAIL lat_level_c1 got %0d exp 2", a_level); end
      end
      checks++; if (a_m_valid !== ev[c]) begin errors++; $display("FAIL lat_m_valid c%0d got %0b exp %0b", c, a_m_valid, ev[c]); end
      if (ev[c]) begin
        checks++; if (a_m_data !== ed[c]) begin errors++; $display("FAIL lat_m_data c%0d got %h exp %h", c, a_m_data, ed[c]); end
      end
    end
    checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL lat_level_end got %0d exp 0", a_level); end
  endtask

  task automatic test_fill();
    int hs;
    int got;
    hs = 0;
    do_reset();
    // Reads keep moving words into the output buffer, so six wide words fit before stored exceeds 6.
    for (int c = 0; c < 10; c++) begin
      tick();
      a_m_ready = 0; a_s_valid = 1; a_s_data = wa(16'h100, hs);
      smp();
      checks++; if (a_level !== 4'(2 * ((c < 6) ? c : 6))) begin errors++; $display("FAIL fill_level c%0d got %0d exp %0d", c, a_level, 2 * ((c < 6) ? c : 6)); end
      checks++; if (a_s_ready !== (c < 6)) begin errors++; $display("FAIL fill_s_ready c%0d got %0b exp %0b", c, a_s_ready, c < 6); end
      checks++; if (a_wea !== (c < 6)) begin errors++; $display("FAIL fill_wea c%0d got %0b exp %0b", c, a_wea, c < 6); end
      if (a_s_valid && a_s_ready) hs++;
    end
    tick();
    a_s_valid = 0;
    smp();
    checks++; if (hs != 6) begin errors++; $display("FAIL fill_handshakes got %0d exp 6", hs); end
    checks++; if (a_level !== 4'd12) begin errors++; $display("FAIL fill_level_full got %0d exp 12", a_level); end
    checks++; if (a_m_data !== 16'h100 || a_m_valid !== 1'b1) begin errors++; $display("FAIL fill_head got %b/%h exp 1/0100", a_m_valid, a_m_data); end
    got = 0;
    for (int c = 0; c < 60 && got < 12; c++) begin
      tick();
      a_m_ready = 1;
      smp();
      if (c < 4) begin
        checks++; if (a_s_ready !== (c == 3)) begin errors++; $display("FAIL drain_s_ready d%0d got %0b exp %0b", c, a_s_ready, c == 3); end
      end
      if (a_m_valid) begin
        checks++; if (a_m_data !== 16'(16'h100 + got)) begin errors++; $display("FAIL drain_data %0d got %h exp %h", got, a_m_data, 16'(16'h100 + got)); end
        got++;
      end
    end
    tick();
    smp();
    checks++; if (got != 12) begin errors++; $display("FAIL drain_count got %0d exp 12", got); end
    checks++; if (a_level !== 4'd0 || a_m_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got level %0d valid %0b exp 0 0", a_level, a_m_valid); end
  endtask

  task automatic test_stream();
    int hs, got, gaps;
    hs = 0; got = 0; gaps = 0;
    do_reset();
    for (int c = 0; c < 200 && got < 40; c++) begin
      tick();
      a_m_ready = 1;
      a_s_valid = (hs < 20);
      a_s_data  = wa(16'h400, hs);
      smp();
      if (a_s_valid && a_s_ready) hs++;
      if (a_m_valid) begin
        checks++; if (a_m_data !== 16'(16'h400 + got)) begin errors++; $display("FAIL stream_data %0d got %h exp %h", got, a_m_data, 16'(16'h400 + got)); end
        got++;
      end else if (got > 0) begin
        gaps++;
      end
    end
    tick();
    a_s_valid = 0;
    smp();
    checks++; if (got != 40) begin errors++; $display("FAIL stream_count got %0d exp 40", got); end
    checks++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d exp 0", gaps); end
    checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL stream_level got %0d exp 0", a_level); end
  endtask

  task automatic test_backpressure();
    logic [15:0] q[$];
    logic [31:0] pend;
    logic [15:0] exp_w;
    int sent, rcvd, lvl, max_ob;
    sent = 0; rcvd = 0; lvl = 0; max_ob = 0;
    pend = $urandom;
    do_reset();
    for (int c = 0; c < 10000 && rcvd < 1000; c++) begin
      tick();
      a_s_valid = (sent < 500) && ($urandom_range(3) != 0);
      a_s_data  = pend;
      a_m_ready = 1'($urandom_range(1));
      smp();
      checks++; if (a_level !== 4'(lvl)) begin errors++; $display("FAIL bp_level c%0d got %0d exp %0d", c, a_level, lvl); end
      if (int'(u_a.ob_cnt) > max_ob) max_ob = int'(u_a.ob_cnt);
      if (a_s_valid && a_s_ready) begin
        q.push_back(pend[15:0]);
        q.push_back(pend[31:16]);
        sent++; lvl += 2;
        pend = $urandom;
      end
      if (a_m_valid && a_m_ready) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        checks++; if (a_m_data !== exp_w) begin errors++; $display("FAIL bp_data %0d got %h exp %h", rcvd, a_m_data, exp_w); end
        rcvd++; lvl -= 1;
      end
    end
    checks++; if (rcvd != 1000) begin errors++; $display("FAIL bp_count got %0d exp 1000", rcvd); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL bp_leftover got %0d exp 0", q.size()); end
    checks++; if (max_ob > 4) begin errors++; $display("FAIL bp_ob_max got %0d exp <=4", max_ob); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ex [2];
    int got;
    ex = '{16'h5678, 16'h1234};
    got = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      a_m_ready = 0;
      a_s_valid = (c < 3);
      a_s_data  = 32'hDEAD0000 | 32'(c);
      smp();
    end
    checks++; if (a_m_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %0b exp 1", a_m_valid); end
    tick();
    rst_n = 0;
    #1;
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid got %0b exp 0", a_m_valid); end
    checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL rmid_level got %0d exp 0", a_level); end
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    a_m_ready = 1; a_s_valid = 1; a_s_data = 32'h12345678;
    smp();
    for (int c = 1; c <= 10; c++) begin
      tick();
      a_s_valid = 0;
      smp();
      if (a_m_valid) begin
        checks++;
        if (got > 1) begin errors++; $display("FAIL rmid_extra got %h exp none", a_m_data); end
        else if (a_m_data !== ex[got]) begin errors++; $display("FAIL rmid_data %0d got %h exp %h", got, a_m_data, ex[got]); end
        else if (got == 0 && c != 4) begin errors++; $display("FAIL rmid_latency got cycle %0d exp 4", c); end
        got++;
      end
    end
    checks++; if (got != 2) begin errors++; $display("FAIL rmid_count got %0d exp 2", got); end
    checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL rmid_level_end got %0d exp 0", a_level); end
  endtask

  task automatic test_ratio1();
    logic ev [5];
    int   hs, got;
    ev = '{0, 0, 0, 1, 0};
    hs = 0; got = 0;
    do_reset();
    tick();
    b_m_ready = 1; b_s_valid = 1; b_s_data = 16'hBEEF;
    smp();
    checks++; if (b_wea !== 1'b1 || b_addra !== 2'd0 || b_dataa !== 16'hBEEF) begin errors++; $display("FAIL r1_write got %b/%0d/%h exp 1/0/beef", b_wea, b_addra, b_dataa); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      b_s_valid = 0;
      smp();
      checks++; if (b_m_valid !== ev[c]) begin errors++; $display("FAIL r1_m_valid c%0d got %0b exp %0b", c, b_m_valid, ev[c]); end
      if (ev[c]) begin
        checks++; if (b_m_data !== 16'hBEEF) begin errors++; $display("FAIL r1_m_data got %h exp beef", b_m_data); end
      end
    end
    for (int c = 0; c < 60 && got < 6; c++) begin
      tick();
      b_s_valid = (hs < 6);
      b_s_data  = 16'(16'hB000 + hs);
      smp();
      if (b_s_valid && b_s_ready) hs++;
      if (b_m_valid) begin
        checks++; if (b_m_data !== 16'(16'hB000 + got)) begin errors++; $display("FAIL r1_stream %0d got %h exp %h", got, b_m_data, 16'(16'hB000 + got)); end
        got++;
      end
    end
    tick();
    b_s_valid = 0;
    smp();
    checks++; if (got != 6) begin errors++; $display("FAIL r1_count got %0d exp 6", got); end
    checks++; if (b_level !== 3'd0) begin errors++; $display("FAIL r1_level got %0d exp 0", b_level); end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_latency();
    test_fill();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_ratio1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
